// File: rtl/tm1638_frame_sched_if.sv
// Display-content side and TM1638 pin side of the frame sequencer.
// master = the logic that requests frames, slave = the sequencer.
interface tm1638_frame_sched_if;
    logic       req;
    logic [3:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [7:0] led;
    logic [2:0] brightness;
    logic       display_on;
    logic       clk;
    logic       stb;
    logic       dio;
    logic       busy;
    logic       frame_done;

    modport master (
        output req, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
        output led, brightness, display_on,
        input  clk, stb, dio, busy, frame_done
    );

    modport slave (
        input  req, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
        input  led, brightness, display_on,
        output clk, stb, dio, busy, frame_done
    );
endinterface

// File: rtl/tm1638_frame_sched.sv
// TM1638 frame sequencer: snapshot digits/LEDs/brightness, then send 0x40, 0xC0 + 16 data bytes, display control.
// Optional leading-zero blanking of seg0..seg6 when TM1638_LEADING_ZERO_BLANK_EN is defined.
module tm1638_frame_sched #(
    parameter int CLK_DIV = 4
) (
    input  logic                 clkinput,
    input  logic                 rst,
    tm1638_frame_sched_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, START, BIT_LO, BIT_HI, END} state_t;

    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    state_t         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic [2:0]     bit_q, bit_d;
    logic [4:0]     byte_q, byte_d;
    logic [1:0]     trans_q, trans_d;
    logic           load;
    logic           tick;
    logic [4:0]     last_byte;

    logic [3:0]     digit_q [8];
    logic [7:0]     led_q;
    logic [2:0]     bright_q;
    logic           on_q;
    logic [7:0]     blank;

    logic [7:0]     tx_byte;
    logic [2:0]     led_idx;

    logic           stb_q, sclk_q, dio_q, busy_q, done_q;
    logic           stb_d, sclk_d, dio_d, busy_d, done_d;

    function automatic logic [7:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 8'h3F;  4'h1: font = 8'h06;  4'h2: font = 8'h5B;  4'h3: font = 8'h4F;
            4'h4: font = 8'h66;  4'h5: font = 8'h6D;  4'h6: font = 8'h7D;  4'h7: font = 8'h07;
            4'h8: font = 8'h7F;  4'h9: font = 8'h6F;  4'hA: font = 8'h77;  4'hB: font = 8'h7C;
            4'hC: font = 8'h39;  4'hD: font = 8'h5E;  4'hE: font = 8'h79;  default: font = 8'h71;
        endcase
    endfunction

    assign tick      = (div_q == DIV_LAST);
    assign last_byte = (trans_q == 2'd1) ? 5'd16 : 5'd0;

`ifdef TM1638_LEADING_ZERO_BLANK_EN
    // A digit is blanked while every digit to its left (and itself) is zero; seg7 always shows.
    always_comb begin
        logic run;
        blank = '0;
        run   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run      = run && (digit_q[i] == 4'd0);
            blank[i] = run;
        end
    end
`else
    assign blank = '0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DW'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        trans_d = trans_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (bus.req) begin
                    load    = 1'b1;
                    state_d = START;
                    trans_d = 2'd0;
                    byte_d  = 5'd0;
                    bit_d   = 3'd0;
                end
            end
            START:  if (tick) state_d = BIT_LO;
            BIT_LO: if (tick) state_d = BIT_HI;
            BIT_HI: begin
                if (tick) begin
                    state_d = BIT_LO;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (byte_q == last_byte) state_d = END;
                        else                     byte_d  = byte_q + 5'd1;
                    end
                end
            end
            END: begin
                if (tick) begin
                    if (trans_q == 2'd2) begin
                        state_d = IDLE;
                    end else begin
                        state_d = START;
                        trans_d = trans_q + 2'd1;
                        byte_d  = 5'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte addressed by the next-cycle indices; odd bytes of transaction 1 are digits, even ones LEDs.
    always_comb begin
        led_idx = byte_d[3:1] - 3'd1;
        tx_byte = 8'h40;
        case (trans_d)
            2'd0: tx_byte = 8'h40;
            2'd1: begin
                if (byte_d == 5'd0)  tx_byte = 8'hC0;
                else if (byte_d[0])  tx_byte = blank[byte_d[3:1]] ? 8'h00 : font(digit_q[byte_d[3:1]]);
                else                 tx_byte = {7'b0, led_q[led_idx]};
            end
            default: tx_byte = on_q ? {5'b10001, bright_q} : 8'h80;
        endcase
    end

    // Pin levels for the next cycle, so that every output leaves a flop.
    always_comb begin
        stb_d  = !(state_d == START || state_d == BIT_LO || state_d == BIT_HI);
        sclk_d = (state_d != BIT_LO);
        dio_d  = (state_d == BIT_LO || state_d == BIT_HI) ? tx_byte[bit_d] : 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_d == END) && (trans_d == 2'd2) && (div_d == DIV_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkinput or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            trans_q <= '0;
            stb_q   <= 1'b1;
            sclk_q  <= 1'b1;
            dio_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            trans_q <= trans_d;
            stb_q   <= stb_d;
            sclk_q  <= sclk_d;
            dio_q   <= dio_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the shadow registers are only read after a load, so they take no reset.
    always_ff @(posedge clkinput) begin
        if (load) begin
            digit_q[0] <= bus.seg0;
            digit_q[1] <= bus.seg1;
            digit_q[2] <= bus.seg2;
            digit_q[3] <= bus.seg3;
            digit_q[4] <= bus.seg4;
            digit_q[5] <= bus.seg5;
            digit_q[6] <= bus.seg6;
            digit_q[7] <= bus.seg7;
            led_q      <= bus.led;
            bright_q   <= bus.brightness;
            on_q       <= bus.display_on;
        end
    end

    assign bus.stb        = stb_q;
    assign bus.clk        = sclk_q;
    assign bus.dio        = dio_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_tm1638_frame_sched.sv
// Bench for tm1638_frame_sched: a TM1638 receiver model decodes the pins and checks bytes
// against a scoreboard filled when each frame is requested.
module tb_tm1638_frame_sched;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 310 * CLK_DIV;
    localparam logic [7:0] FONT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    logic clkinput = 1'b0;
    logic rst      = 1'b1;

    tm1638_frame_sched_if bus ();

    tm1638_frame_sched #(.CLK_DIV(CLK_DIV)) dut (
        .clkinput (clkinput),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clkinput = ~clkinput;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];
    int         len_q [$];

    logic [3:0] seg_v [8];
    logic [7:0] led_v;
    logic [2:0] bri_v;
    logic       on_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_digit(input int i);
`ifdef TM1638_LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
        for (int k = 0; k <= i; k++) if (seg_v[k] != 4'd0) lead = 1'b0;
        if (i < 7 && lead) return 8'h00;
`endif
        return FONT[seg_v[i]];
    endfunction

    task automatic apply_inputs();
        bus.seg0 = seg_v[0]; bus.seg1 = seg_v[1]; bus.seg2 = seg_v[2]; bus.seg3 = seg_v[3];
        bus.seg4 = seg_v[4]; bus.seg5 = seg_v[5]; bus.seg6 = seg_v[6]; bus.seg7 = seg_v[7];
        bus.led        = led_v;
        bus.brightness = bri_v;
        bus.display_on = on_v;
    endtask

    task automatic push_frame();
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(exp_digit(i));
            exp_q.push_back({7'b0, led_v[i]});
        end
        exp_q.push_back(on_v ? (8'h88 | {5'b0, bri_v}) : 8'h80);
        len_q.push_back(1);
        len_q.push_back(17);
        len_q.push_back(1);
    endtask

    // One-cycle req pulse; returns on the first cycle of the frame.
    task automatic start_frame();
        @(negedge clkinput) bus.req = 1'b1;
        @(negedge clkinput) bus.req = 1'b0;
        check("stb_fall", bus.stb, 1'b0);
        check("busy_rise", bus.busy, 1'b1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.frame_done !== 1'b1 && cycles < 3 * FRAME) begin
            @(negedge clkinput);
            cycles++;
        end
        check("done_seen", bus.frame_done, 1'b1);
    endtask

    // TM1638 receiver: samples dio on clk rising edges while stb is low.
    initial begin
        logic       prev_clk, prev_stb;
        logic [7:0] sh;
        int         bits, nbytes;
        prev_clk = 1'b1;
        prev_stb = 1'b1;
        sh       = '0;
        bits     = 0;
        nbytes   = 0;
        forever begin
            @(negedge clkinput);
            if (bus.stb === 1'b0 && prev_stb === 1'b1) begin
                bits   = 0;
                nbytes = 0;
            end
            if (bus.stb === 1'b0 && bus.clk === 1'b1 && prev_clk === 1'b0) begin
                sh = {bus.dio, sh[7:1]};
                bits++;
                if (bits % 8 == 0) begin
                    nbytes++;
                    if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
                    else                   check("byte", sh, exp_q.pop_front());
                end
            end
            if (bus.stb === 1'b1 && prev_stb === 1'b0) begin
                if (len_q.size() == 0) check("len_underflow", len_q.size(), 1);
                else                   check("trans_len", nbytes, len_q.pop_front());
            end
            prev_clk = bus.clk;
            prev_stb = bus.stb;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  extra;
        bus.req = 1'b0;
        seg_v = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd9, 4'd1, 4'd6, 4'd6};
        led_v = 8'h00; bri_v = 3'd7; on_v = 1'b1;
        apply_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clkinput);
        check("rst_stb", bus.stb, 1'b1);
        check("rst_clk", bus.clk, 1'b1);
        check("rst_dio", bus.dio, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.frame_done, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clkinput);

        // Reference frame: 2,2,1,1,9,1,6,6 at full brightness.
        push_frame();
        start_frame();
        wait_done(n);
        check("done_latency", n, FRAME - 1);
        check("busy_at_done", bus.busy, 1'b1);
        @(negedge clkinput);
        check("busy_fall", bus.busy, 1'b0);
        check("done_pulse", bus.frame_done, 1'b0);
        check("idle_stb", bus.stb, 1'b1);

        // Inputs changed mid-frame must not tear the transmitted frame.
        seg_v = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h7};
        led_v = 8'hA5; bri_v = 3'd3; on_v = 1'b1;
        apply_inputs();
        push_frame();
        start_frame();
        repeat (600) @(negedge clkinput);
        seg_v = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        led_v = 8'h3C; bri_v = 3'd5; on_v = 1'b1;
        apply_inputs();
        wait_done(n);
        check("tear_latency", n, FRAME - 601);
        @(negedge clkinput);
        push_frame();
        start_frame();
        wait_done(n);
        @(negedge clkinput);

        // Back-to-back refresh with req held, then req pulses during busy.
        seg_v = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        led_v = 8'hFF; bri_v = 3'd0; on_v = 1'b1;
        apply_inputs();
        push_frame();
        push_frame();
        bus.req = 1'b1;
        @(negedge clkinput);
        check("b2b_first_stb", bus.stb, 1'b0);
        wait_done(n);
        check("b2b_latency", n, FRAME - 1);
        @(negedge clkinput);
        check("gap_busy", bus.busy, 1'b0);
        check("gap_stb", bus.stb, 1'b1);
        @(negedge clkinput);
        check("b2b_stb", bus.stb, 1'b0);
        check("b2b_busy", bus.busy, 1'b1);
        bus.req = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (100) @(negedge clkinput);
            bus.req = 1'b1;
            @(negedge clkinput);
            bus.req = 1'b0;
        end
        wait_done(n);
        extra = 1'b0;
        repeat (20) begin
            @(negedge clkinput);
            if (bus.busy !== 1'b0 || bus.stb !== 1'b1) extra = 1'b1;
        end
        check("no_extra_frame", extra, 1'b0);

        // Reset during the 5th BIT_HI of transaction 1 (cycle 112..115 of the frame).
        seg_v = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd9, 4'd1, 4'd6, 4'd6};
        led_v = 8'h81; bri_v = 3'd2; on_v = 1'b0;
        apply_inputs();
        exp_q.push_back(8'h40);
        len_q.push_back(1);
        len_q.push_back(0);
        start_frame();
        repeat (113) @(negedge clkinput);
        check("abort_pt_clk", bus.clk, 1'b1);
        check("abort_pt_stb", bus.stb, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_stb", bus.stb, 1'b1);
        check("abort_clk", bus.clk, 1'b1);
        check("abort_dio", bus.dio, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        @(negedge clkinput);
        rst = 1'b0;
        @(negedge clkinput);
        push_frame();
        start_frame();
        wait_done(n);
        check("post_rst_latency", n, FRAME - 1);
        @(negedge clkinput);

        // All-zero digits with display off, then a single nonzero digit.
        seg_v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        led_v = 8'h01; bri_v = 3'd6; on_v = 1'b0;
        apply_inputs();
        push_frame();
        start_frame();
        wait_done(n);
        @(negedge clkinput);
        seg_v = '{4'd0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
        led_v = 8'h10; bri_v = 3'd1; on_v = 1'b1;
        apply_inputs();
        push_frame();
        start_frame();
        wait_done(n);
        repeat (4) @(negedge clkinput);

        check("sb_empty", exp_q.size(), 0);
        check("len_empty", len_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tm1638_frame_sched.md
# tm1638_frame_sched

Frame sequencer for the TM1638 LED/7-segment board: on request it snapshots eight hex digits, eight LED bits and a brightness setting, then drives the complete TM1638 write protocol on `stb`/`clk`/`dio`. The protocol is: set auto-increment mode, write 16 bytes from address 0, then set display control. It sits between the display-content logic (fixed student-ID digits, counters) and the board pins, and runs from the divided clock produced by the clock-divider block.

## Interface
- `CLK_DIV`, default 4: `clkinput` cycles per half bit period on `clk`; legal range ≥1.
- `clkinput` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: frame request, level-sampled in IDLE.
- `seg0`..`seg7` in 4 each: hex digit per position; `seg0` is the leftmost digit at address 0x00.
- `led` in 8: `led[i]` lights the LED at address 0x01+2i.
- `brightness` in 3: PWM level sent in the display-control command.
- `display_on` in 1: display enable sent in the display-control command.
- `clk` out 1: TM1638 serial clock.
- `stb` out 1: TM1638 strobe, active low.
- `dio` out 1: TM1638 data, driven only (write-only).
- `busy` out 1: high while a frame is in progress.
- `frame_done` out 1: one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, BIT_LO, BIT_HI, END. A transaction counter (0..2) and a byte counter (0..16) select the current byte.
- IDLE: if `req`=1, snapshot all data inputs into shadow registers, set `busy`=1, and enter START for transaction 0 on the next cycle.
- Transaction 0 sends 1 byte: 0x40.
- Transaction 1 sends 17 bytes: 0xC0, then for i=0..7 the byte pair `font(seg_i)`, `{7'b0, led[i]}`.
- Transaction 2 sends 1 byte: `display_on` ? (0x88 | `brightness`) : 0x80.
- START: `stb`=0, `clk`=1.
- Bits go out LSB first. BIT_LO: `clk`=0, `dio`=current bit. BIT_HI: `clk`=1, `dio` held. The TM1638 samples on the `clk` rising edge.
- After the last bit of a transaction's last byte, go to END: `stb`=1, `clk`=1, `dio`=1.
- After END of transaction 2: pulse `frame_done`, clear `busy`, and go to IDLE.
- Font (gfedcba, dp=0): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Inputs changing mid-frame have no effect; only the snapshot is transmitted (no tearing).
- `req` is ignored while `busy`=1. If `req` is still high in the cycle after `frame_done`, the next frame starts (back-to-back refresh).

## Timing
- Reset values: `stb`=1, `clk`=1, `dio`=1, `busy`=0, `frame_done`=0, state IDLE.
- Reset mid-frame returns all outputs to reset values immediately (async). A raised `stb` aborts the transaction on the chip.
- Each of START, BIT_LO, BIT_HI and END lasts exactly `CLK_DIV` cycles.
- An n-byte transaction takes (2+16n)·`CLK_DIV` cycles. A frame takes 310·`CLK_DIV` cycles (1240 at default).
- First `stb` fall occurs 1 cycle after the `req` sample. `busy` rises in the same cycle as the `stb` fall.
- `frame_done` asserts on the last END cycle of transaction 2. `busy` falls in the following cycle.
- All outputs are registered; there are no combinational paths from inputs to pins.

## Configuration
- `TM1638_LEADING_ZERO_BLANK_EN` defined:
  - Scanning `seg0`→`seg6`, every snapshot digit equal to 0 that precedes the first nonzero digit is sent as 0x00.
  - `seg7` is never blanked, so all-zero input shows a single "0" at the rightmost digit.
- Undefined: every digit is sent through the font unchanged.

## Test plan
- Reset, then `req`=1 one cycle with seg0..7=2,2,1,1,9,1,6,6, `led`=0, `brightness`=7, `display_on`=1, `CLK_DIV`=4:
  - Decoded bytes are 0x40; 0xC0,5B,00,5B,00,06,00,06,00,6F,00,06,00,7D,00,7D,00; 0x8F.
  - `frame_done` occurs 1240 cycles after the first `stb` fall.
- Change all seg/led inputs at cycle 600 of a frame -> transmitted bytes still match the snapshot; the new values appear only in the next frame.
- Hold `req`=1 continuously -> frames repeat with IDLE lasting exactly 1 cycle between `frame_done` and the next `stb` fall; `req` pulses during `busy` produce no extra frame.
- Assert `rst` at the 5th BIT_HI of transaction 1 -> `stb`=`clk`=`dio`=1 and `busy`=0 immediately. After release with `req`=1, a full, correct frame follows.
- With the macro defined, seg=0,0,0,4,0,0,0,0 -> digit bytes 00,00,00,66,3F,3F,3F,3F. All-zero input -> seven 0x00 then 0x3F. `display_on`=0 -> last command 0x80.
